// File: rtl/zap_mmu_wb_arbiter.sv
// zap_mmu_wb_arbiter
// Two-master Wishbone arbiter for the MMU side of the core. Port 0 is the TLB
// page-walk FSM and port 1 is the cache line-fill/writeback FSM. A grant is
// held for the whole Wishbone cycle (until the granted master drops cyc).
// Every grant is followed by one dead IDLE cycle, and arbitration happens
// only in IDLE. A sticky flag reports a granted strobe that stays unacked.
module zap_mmu_wb_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // Walker (port 0)
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_wen,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  output logic        o_m0_ack,
  // Cache FSM (port 1)
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_wen,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  output logic        o_m1_ack,
  // Shared read data
  output logic [31:0] o_m_dat,
  // Bus side
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  // Status
  output logic [1:0]  o_gnt,
  output logic        o_timeout,
  input  logic        i_timeout_clr
);

  // One extra bit so the counter can hold TIMEOUT_CYCLES itself when saturated.
  localparam int             CW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0]  TMO_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  TMO_SET = CW'(TIMEOUT_CYCLES - 1);
  localparam logic           RR_EN   = (ROUND_ROBIN != 0);

  // Fewer than two timeout cycles leaves no room for a normal single-wait ack.
  if (TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("zap_mmu_wb_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          state_ff;
  logic            last_ff;     // last granted port (0 or 1)
  logic [CW-1:0]   tmo_cnt_ff;
  logic            tmo_ff;

  // Saturating increment of the unacked-strobe counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= TMO_MAX) ? TMO_MAX : v + CW'(1);
  endfunction

  // Steer the granted master onto the bus and route ack back to it only.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_wen = 1'b0;
    o_wb_sel = 4'h0;
    o_wb_adr = 32'h0;
    o_wb_dat = 32'h0;
    o_m0_ack = 1'b0;
    o_m1_ack = 1'b0;
    case (state_ff)
      GNT0: begin
        o_wb_cyc = i_m0_cyc;
        o_wb_stb = i_m0_stb;
        o_wb_wen = i_m0_wen;
        o_wb_sel = i_m0_sel;
        o_wb_adr = i_m0_adr;
        o_wb_dat = i_m0_dat;
        o_m0_ack = i_wb_ack;
      end
      GNT1: begin
        o_wb_cyc = i_m1_cyc;
        o_wb_stb = i_m1_stb;
        o_wb_wen = i_m1_wen;
        o_wb_sel = i_m1_sel;
        o_wb_adr = i_m1_adr;
        o_wb_dat = i_m1_dat;
        o_m1_ack = i_wb_ack;
      end
      default: ;
    endcase
  end

  assign o_m_dat   = i_wb_dat;
  assign o_gnt     = {state_ff == GNT1, state_ff == GNT0};
  assign o_timeout = tmo_ff;

  // Grant FSM: arbitrate only in IDLE, hold until the granted cyc drops.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_ff <= IDLE;
      last_ff  <= 1'b0;
    end else begin
      case (state_ff)
        IDLE: begin
          if (i_m0_cyc && i_m1_cyc) begin
            if (RR_EN && !last_ff) begin
              state_ff <= GNT1;
              last_ff  <= 1'b1;
            end else begin
              state_ff <= GNT0;
              last_ff  <= 1'b0;
            end
          end else if (i_m0_cyc) begin
            state_ff <= GNT0;
            last_ff  <= 1'b0;
          end else if (i_m1_cyc) begin
            state_ff <= GNT1;
            last_ff  <= 1'b1;
          end
        end
        GNT0:    if (!i_m0_cyc) state_ff <= IDLE;
        GNT1:    if (!i_m1_cyc) state_ff <= IDLE;
        default: state_ff <= IDLE;
      endcase
    end
  end

  // Count unacked granted strobes; a set of the sticky flag beats a clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_cnt_ff <= '0;
      tmo_ff     <= 1'b0;
    end else begin
      if (o_wb_stb && !i_wb_ack)
        tmo_cnt_ff <= sat_inc(tmo_cnt_ff);
      else
        tmo_cnt_ff <= '0;

      if (tmo_cnt_ff >= TMO_SET)
        tmo_ff <= 1'b1;
      else if (i_timeout_clr)
        tmo_ff <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zap_mmu_wb_arbiter.sv
// tb_zap_mmu_wb_arbiter
// Table-driven bench for the MMU Wishbone arbiter. Instance "dut" runs with
// round-robin arbitration and an 8-cycle timeout; instance "dut_fp" runs with
// fixed priority for the port-0-wins ordering sequence.
module tb_zap_mmu_wb_arbiter;

  localparam logic [31:0] A0 = 32'h0000_4008;
  localparam logic [31:0] A1 = 32'h8000_0100;
  localparam logic [31:0] D0 = 32'hDEAD_0000;
  localparam logic [31:0] D1 = 32'h1234_5678;
  localparam logic [3:0]  S0 = 4'hF;
  localparam logic [3:0]  S1 = 4'h3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared constant request attributes
  logic        m0_wen, m1_wen;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat;

  // Round-robin instance signals
  logic        rst, m0_cyc, m0_stb, m1_cyc, m1_stb, wb_ack, tmo_clr;
  logic [31:0] wb_rdat;
  logic        m0_ack, m1_ack, wb_cyc, wb_stb, wb_wen, timeout;
  logic [3:0]  wb_sel;
  logic [31:0] m_dat, wb_adr, wb_wdat;
  logic [1:0]  gnt;

  // Fixed-priority instance signals
  logic        b_rst, b_m0_cyc, b_m0_stb, b_m1_cyc, b_m1_stb, b_ack, b_clr;
  logic [31:0] b_rdat;
  logic        b_m0_ack, b_m1_ack, b_wb_cyc, b_wb_stb, b_wb_wen, b_timeout;
  logic [3:0]  b_wb_sel;
  logic [31:0] b_m_dat, b_wb_adr, b_wb_wdat;
  logic [1:0]  b_gnt;

  zap_mmu_wb_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_wen(m0_wen), .i_m0_sel(m0_sel),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .o_m0_ack(m0_ack),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_wen(m1_wen), .i_m1_sel(m1_sel),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .o_m1_ack(m1_ack),
    .o_m_dat(m_dat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_wen(wb_wen), .o_wb_sel(wb_sel),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_wdat), .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack),
    .o_gnt(gnt), .o_timeout(timeout), .i_timeout_clr(tmo_clr)
  );

  zap_mmu_wb_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) dut_fp (
    .i_clk(clk), .i_reset(b_rst),
    .i_m0_cyc(b_m0_cyc), .i_m0_stb(b_m0_stb), .i_m0_wen(m0_wen), .i_m0_sel(m0_sel),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .o_m0_ack(b_m0_ack),
    .i_m1_cyc(b_m1_cyc), .i_m1_stb(b_m1_stb), .i_m1_wen(m1_wen), .i_m1_sel(m1_sel),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .o_m1_ack(b_m1_ack),
    .o_m_dat(b_m_dat),
    .o_wb_cyc(b_wb_cyc), .o_wb_stb(b_wb_stb), .o_wb_wen(b_wb_wen), .o_wb_sel(b_wb_sel),
    .o_wb_adr(b_wb_adr), .o_wb_dat(b_wb_wdat), .i_wb_dat(b_rdat), .i_wb_ack(b_ack),
    .o_gnt(b_gnt), .o_timeout(b_timeout), .i_timeout_clr(b_clr)
  );

  // One table row: inputs for one cycle and the outputs expected in that cycle.
  typedef struct {
    logic       rst, c0, s0, c1, s1, ack, clr;
    logic [1:0] gnt;
    logic       a0, a1, cyc, tmo;
  } vec_t;

  // Full expected output set pushed to the scoreboard.
  typedef struct {
    logic [1:0]  gnt;
    logic        a0, a1, cyc, stb, wen, tmo;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, mdat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, cyc_idx, act, req);
    end
  endtask

  task automatic add(input logic r, c0, s0, c1, s1, ack, clr,
                     input logic [1:0] g, input logic a0, a1, cyc, tmo);
    vec_t v;
    v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.clr = clr;
    v.gnt = g; v.a0 = a0; v.a1 = a1; v.cyc = cyc; v.tmo = tmo;
    vecs.push_back(v);
  endtask

  // Drive one row after the edge, push its expectation, compare at negedge.
  task automatic apply(input vec_t v, input logic [31:0] rdat);
    exp_t e, g;
    @(posedge clk);
    #1;
    rst = v.rst; m0_cyc = v.c0; m0_stb = v.s0; m1_cyc = v.c1; m1_stb = v.s1;
    wb_ack = v.ack; tmo_clr = v.clr; wb_rdat = rdat;
    e.gnt  = v.gnt; e.a0 = v.a0; e.a1 = v.a1; e.cyc = v.cyc; e.tmo = v.tmo;
    e.stb  = (v.gnt == 2'b01) ? v.s0 : (v.gnt == 2'b10) ? v.s1 : 1'b0;
    e.wen  = (v.gnt == 2'b10);
    e.sel  = (v.gnt == 2'b01) ? S0 : (v.gnt == 2'b10) ? S1 : 4'h0;
    e.adr  = (v.gnt == 2'b01) ? A0 : (v.gnt == 2'b10) ? A1 : 32'h0;
    e.wdat = (v.gnt == 2'b01) ? D0 : (v.gnt == 2'b10) ? D1 : 32'h0;
    e.mdat = rdat;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      chk("gnt",     32'(gnt),     32'(g.gnt));
      chk("m0_ack",  32'(m0_ack),  32'(g.a0));
      chk("m1_ack",  32'(m1_ack),  32'(g.a1));
      chk("wb_cyc",  32'(wb_cyc),  32'(g.cyc));
      chk("wb_stb",  32'(wb_stb),  32'(g.stb));
      chk("wb_wen",  32'(wb_wen),  32'(g.wen));
      chk("wb_sel",  32'(wb_sel),  32'(g.sel));
      chk("wb_adr",  wb_adr,       g.adr);
      chk("wb_dat",  wb_wdat,      g.wdat);
      chk("m_dat",   m_dat,        g.mdat);
      chk("timeout", 32'(timeout), 32'(g.tmo));
    end
  endtask

  task automatic b_step(input logic c0, s0, c1, s1, input logic [1:0] g);
    @(posedge clk);
    #1;
    b_rst = 1'b0; b_m0_cyc = c0; b_m0_stb = s0; b_m1_cyc = c1; b_m1_stb = s1;
    @(negedge clk);
    chk("fp_gnt", 32'(b_gnt), 32'(g));
  endtask

  initial begin
    m0_wen = 1'b0; m0_sel = S0; m0_adr = A0; m0_dat = D0;
    m1_wen = 1'b1; m1_sel = S1; m1_adr = A1; m1_dat = D1;
    rst = 1'b1; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    wb_ack = 0; tmo_clr = 0; wb_rdat = '0;
    b_rst = 1'b1; b_m0_cyc = 0; b_m0_stb = 0; b_m1_cyc = 0; b_m1_stb = 0;
    b_ack = 0; b_clr = 0; b_rdat = '0;

    // Walker alone: grant after one cycle, ack on the third bus cycle
    add(0,1,1,0,0,0,0, 2'b00,0,0,0,0);
    add(0,1,1,0,0,0,0, 2'b01,0,0,1,0);
    add(0,1,1,0,0,0,0, 2'b01,0,0,1,0);
    add(0,1,1,0,0,1,0, 2'b01,1,0,1,0);
    add(0,0,0,0,0,0,0, 2'b01,0,0,0,0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,0,0);
    // Simultaneous requests with last grant = port 0: port 1 first
    add(0,1,1,1,1,0,0, 2'b00,0,0,0,0);
    add(0,1,1,1,1,0,0, 2'b10,0,0,1,0);
    add(0,1,1,1,1,1,0, 2'b10,0,1,1,0);
    add(0,1,1,0,0,0,0, 2'b10,0,0,0,0);
    add(0,1,1,0,0,0,0, 2'b00,0,0,0,0);
    add(0,1,1,0,0,1,0, 2'b01,1,0,1,0);
    add(0,0,0,0,0,0,0, 2'b01,0,0,0,0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,0,0);
    // Burst of four acks on port 1 while port 0 requests mid-burst
    add(0,0,0,1,1,0,0, 2'b00,0,0,0,0);
    add(0,0,0,1,1,1,0, 2'b10,0,1,1,0);
    for (int k = 0; k < 3; k++) add(0,1,1,1,1,1,0, 2'b10,0,1,1,0);
    add(0,1,1,0,0,0,0, 2'b10,0,0,0,0);
    add(0,1,1,0,0,0,0, 2'b00,0,0,0,0);
    add(0,1,1,0,0,1,0, 2'b01,1,0,1,0);
    add(0,0,0,0,0,0,0, 2'b01,0,0,0,0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,0,0);
    // Timeout: eight unacked strobes, then clear versus saturated counter
    add(0,1,1,0,0,0,0, 2'b00,0,0,0,0);
    for (int k = 0; k < 8; k++) add(0,1,1,0,0,0,0, 2'b01,0,0,1,0);
    add(0,1,1,0,0,0,0, 2'b01,0,0,1,1);
    add(0,1,1,0,0,0,1, 2'b01,0,0,1,1);
    add(0,1,1,0,0,0,0, 2'b01,0,0,1,1);
    add(0,1,0,0,0,0,1, 2'b01,0,0,1,1);
    add(0,1,0,0,0,0,1, 2'b01,0,0,1,1);
    add(0,1,0,0,0,0,0, 2'b01,0,0,1,0);
    add(0,0,0,0,0,0,0, 2'b01,0,0,0,0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,0,0);
    // Reset mid-grant with the timeout flag set; ack after reset is dropped
    add(0,0,0,1,1,0,0, 2'b00,0,0,0,0);
    for (int k = 0; k < 8; k++) add(0,0,0,1,1,0,0, 2'b10,0,0,1,0);
    add(1,0,0,1,1,0,0, 2'b10,0,0,1,1);
    add(0,0,0,1,1,1,0, 2'b00,0,0,0,0);
    add(0,0,0,1,1,1,0, 2'b10,0,1,1,0);
    add(0,0,0,0,0,0,0, 2'b10,0,0,0,0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,0,0);
    // Simultaneous requests with last grant = port 1: port 0 first
    add(0,1,1,1,1,0,0, 2'b00,0,0,0,0);
    add(0,1,1,1,1,0,0, 2'b01,0,0,1,0);
    add(0,0,0,1,1,0,0, 2'b01,0,0,0,0);
    add(0,0,0,1,1,0,0, 2'b00,0,0,0,0);
    add(0,0,0,1,1,0,0, 2'b10,0,0,1,0);
    add(0,0,0,0,0,0,0, 2'b10,0,0,0,0);
    add(0,0,0,0,0,0,0, 2'b00,0,0,0,0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",     32'(gnt),     32'd0);
    chk("rst_wb_cyc",  32'(wb_cyc),  32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_fp_gnt",  32'(b_gnt),   32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc_idx = i;
      apply(vecs[i], (i == 3) ? 32'h0000_0C12 : $urandom());
    end

    // Fixed priority: port 0 wins a tie, port 1 follows after a dead cycle
    cyc_idx = 1000;
    b_step(1,1,1,1, 2'b00);
    b_step(1,1,1,1, 2'b01);
    b_step(0,0,1,1, 2'b01);
    b_step(0,0,1,1, 2'b00);
    b_step(0,0,1,1, 2'b10);
    b_step(0,0,0,0, 2'b10);
    b_step(0,0,0,0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
